// File: rtl/pcf8591_scan_ctrl.sv
// PCF8591 scan sequencer: round-robin channel sweep, one I2C read per channel, watchdog and
// inter-sweep gap. Optional 4-sample averaging is enabled by defining PCF8591_OVERSAMPLE_EN.
module pcf8591_scan_ctrl #(
  parameter int unsigned SCAN_GAP       = 50000,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter bit          AOUT_EN        = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic [3:0] ch_mask,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_ctrl,
  output logic [2:0] cmd_rd_len,
  input  logic [7:0] i2c_rd_data,
  input  logic       i2c_rd_valid,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  output logic [7:0] adc_data,
  output logic       adc_data_valid,
  output logic [1:0] adc_channel,
  output logic       sweep_done,
  output logic       err_timeout,
  output logic       err_nack,
  output logic       busy
);

  localparam int unsigned GapW = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
  localparam int unsigned WdW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(SCAN_GAP - 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT_CYCLES - 1);

`ifdef PCF8591_OVERSAMPLE_EN
  localparam logic [2:0] RdLen = 3'd5;
`else
  localparam logic [2:0] RdLen = 3'd2;
`endif
  localparam logic [2:0] LastByte = RdLen - 3'd1;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StIssue,
    StWaitData,
    StWaitDone,
    StPublish,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      mask_q, mask_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [1:0]      ch_q, ch_d;
  logic [7:0]      ctrl_q, ctrl_d;
  logic [2:0]      rd_len_q, rd_len_d;
  logic [2:0]      byte_cnt_q, byte_cnt_d;
  logic [WdW-1:0]  wdog_q, wdog_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic            err_nack_q, err_nack_d;
  logic            err_timeout_q, err_timeout_d;
`ifdef PCF8591_OVERSAMPLE_EN
  logic [9:0]      acc_q, acc_d;
`else
  logic [7:0]      sample_q, sample_d;
`endif

  // Lowest enabled channel >= ptr; 4 means the sweep is exhausted.
  function automatic logic [2:0] find_next(input logic [3:0] mask, input logic [2:0] ptr);
    find_next = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= ptr)) find_next = 3'(i);
    end
  endfunction

  logic [2:0] sel;
  logic       sel_found;
  logic       last_byte;
  logic [2:0] ptr_next;
  state_e     after_txn;

  assign sel       = find_next(mask_q, ptr_q);
  assign sel_found = ~sel[2];
  assign last_byte = i2c_rd_valid && (byte_cnt_q == LastByte);
  assign ptr_next  = {1'b0, ch_q} + 3'd1;
  // A dropped scan_en lets the current transaction finish, then parks in IDLE.
  assign after_txn = scan_en ? StSelect : StIdle;

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    ptr_d         = ptr_q;
    ch_d          = ch_q;
    ctrl_d        = ctrl_q;
    rd_len_d      = rd_len_q;
    byte_cnt_d    = byte_cnt_q;
    wdog_d        = '0;
    gap_cnt_d     = '0;
    err_nack_d    = 1'b0;
    err_timeout_d = 1'b0;
`ifdef PCF8591_OVERSAMPLE_EN
    acc_d         = acc_q;
`else
    sample_d      = sample_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (scan_en && (ch_mask != 4'b0000)) begin
          mask_d  = ch_mask;
          ptr_d   = 3'd0;
          state_d = StSelect;
        end
      end

      StSelect: begin
        if (!scan_en) begin
          state_d = StIdle;
        end else if (sel_found) begin
          ch_d     = sel[1:0];
          ctrl_d   = {1'b0, AOUT_EN, 4'b0000, sel[1:0]};
          rd_len_d = RdLen;
          state_d  = StIssue;
        end else begin
          state_d = StGap;
        end
      end

      StIssue: begin
        if (cmd_ready) begin
          byte_cnt_d = 3'd0;
          wdog_d     = WdW'(1);
`ifdef PCF8591_OVERSAMPLE_EN
          acc_d      = '0;
`endif
          state_d    = StWaitData;
        end
      end

      StWaitData: begin
        wdog_d = wdog_q + WdW'(1);
        if (i2c_nack) begin
          err_nack_d = 1'b1;
          ptr_d      = ptr_next;
          state_d    = after_txn;
        end else begin
          if (i2c_rd_valid) begin
            byte_cnt_d = byte_cnt_q + 3'd1;
`ifdef PCF8591_OVERSAMPLE_EN
            if (byte_cnt_q != 3'd0) acc_d = acc_q + 10'(i2c_rd_data);
`else
            if (byte_cnt_q == 3'd1) sample_d = i2c_rd_data;
`endif
          end
          if (last_byte && i2c_done) begin
            state_d = StPublish;
          end else if (i2c_done) begin
            // STOP before the last byte: nothing valid to publish, move on.
            ptr_d   = ptr_next;
            state_d = after_txn;
          end else if (wdog_q == WdLast) begin
            err_timeout_d = 1'b1;
            ptr_d         = ptr_next;
            state_d       = after_txn;
          end else if (last_byte) begin
            state_d = StWaitDone;
          end
        end
      end

      StWaitDone: begin
        wdog_d = wdog_q + WdW'(1);
        if (i2c_nack) begin
          err_nack_d = 1'b1;
          ptr_d      = ptr_next;
          state_d    = after_txn;
        end else if (i2c_done) begin
          state_d = StPublish;
        end else if (wdog_q == WdLast) begin
          err_timeout_d = 1'b1;
          ptr_d         = ptr_next;
          state_d       = after_txn;
        end
      end

      StPublish: begin
        ptr_d   = ptr_next;
        state_d = after_txn;
      end

      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      mask_q        <= '0;
      ptr_q         <= '0;
      ch_q          <= '0;
      ctrl_q        <= '0;
      rd_len_q      <= '0;
      byte_cnt_q    <= '0;
      wdog_q        <= '0;
      gap_cnt_q     <= '0;
      err_nack_q    <= 1'b0;
      err_timeout_q <= 1'b0;
`ifdef PCF8591_OVERSAMPLE_EN
      acc_q         <= '0;
`else
      sample_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      ptr_q         <= ptr_d;
      ch_q          <= ch_d;
      ctrl_q        <= ctrl_d;
      rd_len_q      <= rd_len_d;
      byte_cnt_q    <= byte_cnt_d;
      wdog_q        <= wdog_d;
      gap_cnt_q     <= gap_cnt_d;
      err_nack_q    <= err_nack_d;
      err_timeout_q <= err_timeout_d;
`ifdef PCF8591_OVERSAMPLE_EN
      acc_q         <= acc_d;
`else
      sample_q      <= sample_d;
`endif
    end
  end

  assign cmd_valid      = (state_q == StIssue);
  assign cmd_ctrl       = ctrl_q;
  assign cmd_rd_len     = rd_len_q;
  assign adc_data_valid = (state_q == StPublish);
  assign adc_channel    = ch_q;
`ifdef PCF8591_OVERSAMPLE_EN
  assign adc_data       = acc_q[9:2];
`else
  assign adc_data       = sample_q;
`endif
  assign sweep_done     = (state_q == StSelect) && scan_en && !sel_found;
  assign err_timeout    = err_timeout_q;
  assign err_nack       = err_nack_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_pcf8591_scan_ctrl.sv
// Directed bench for pcf8591_scan_ctrl with a hand-driven I2C master model.
module tb_pcf8591_scan_ctrl;

  localparam int unsigned Gap = 10;
  localparam int unsigned Tmo = 100;
`ifdef PCF8591_OVERSAMPLE_EN
  localparam int RdLen = 5;
  localparam logic [7:0] AvgExp = 8'h28;
`else
  localparam int RdLen = 2;
  localparam logic [7:0] AvgExp = 8'h10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scan_en;
  logic [3:0] ch_mask;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_ctrl;
  logic [2:0] cmd_rd_len;
  logic [7:0] i2c_rd_data;
  logic       i2c_rd_valid;
  logic       i2c_done;
  logic       i2c_nack;
  logic [7:0] adc_data;
  logic       adc_data_valid;
  logic [1:0] adc_channel;
  logic       sweep_done;
  logic       err_timeout;
  logic       err_nack;
  logic       busy;

  pcf8591_scan_ctrl #(
    .SCAN_GAP      (Gap),
    .TIMEOUT_CYCLES(Tmo),
    .AOUT_EN       (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .scan_en       (scan_en),
    .ch_mask       (ch_mask),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_ctrl      (cmd_ctrl),
    .cmd_rd_len    (cmd_rd_len),
    .i2c_rd_data   (i2c_rd_data),
    .i2c_rd_valid  (i2c_rd_valid),
    .i2c_done      (i2c_done),
    .i2c_nack      (i2c_nack),
    .adc_data      (adc_data),
    .adc_data_valid(adc_data_valid),
    .adc_channel   (adc_channel),
    .sweep_done    (sweep_done),
    .err_timeout   (err_timeout),
    .err_nack      (err_nack),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid, n_sweep, n_nack, n_to, n_cmdv, n_busy;
  int sweep_cyc, to_cyc, hs_cyc, rise_cyc, hold_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_valid = 0; n_sweep = 0; n_nack = 0; n_to = 0; n_cmdv = 0; n_busy = 0;
    sweep_cyc = 0; to_cyc = 0;
  endtask

  // Advance to the next falling edge and record the output strobes seen there.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (adc_data_valid) n_valid++;
    if (sweep_done) begin n_sweep++; sweep_cyc = cyc; end
    if (err_nack) n_nack++;
    if (err_timeout) begin n_to++; to_cyc = cyc; end
    if (cmd_valid) n_cmdv++;
    if (busy) n_busy++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; scan_en = 1'b0; ch_mask = 4'b0000; cmd_ready = 1'b0;
    i2c_rd_data = 8'h00; i2c_rd_valid = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    clear_counts();
  endtask

  task automatic wait_cmd(input logic [7:0] exp_ctrl, input string tag);
    int n = 0;
    while (!cmd_valid && n < 500) begin tick(); n++; end
    chk({tag, "_seen"}, {31'd0, cmd_valid}, 32'd1);
    rise_cyc = cyc;
    chk({tag, "_ctrl"}, {24'd0, cmd_ctrl}, {24'd0, exp_ctrl});
    chk({tag, "_rdlen"}, {29'd0, cmd_rd_len}, 32'(RdLen));
  endtask

  task automatic handshake();
    cmd_ready = 1'b1;
    hs_cyc = cyc;
    tick();
    cmd_ready = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic with_done);
    i2c_rd_data = b; i2c_rd_valid = 1'b1; i2c_done = with_done;
    tick();
    i2c_rd_valid = 1'b0; i2c_done = 1'b0;
  endtask

  task automatic pulse_done();
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
  endtask

  // Stale byte, then the fresh value repeated so the average equals it in either build.
  task automatic send_sample(input logic [7:0] stale, input logic [7:0] fresh);
    send_byte(stale, 1'b0);
    for (int i = 1; i < RdLen; i++) send_byte(fresh, 1'b0);
  endtask

  task automatic chk_pub(input string tag, input logic [7:0] d, input logic [1:0] ch);
    chk({tag, "_valid"}, {31'd0, adc_data_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, adc_data}, {24'd0, d});
    chk({tag, "_ch"}, {30'd0, adc_channel}, {30'd0, ch});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    // Reset state.
    rst_n = 1'b0; scan_en = 1'b0; ch_mask = 4'b0000; cmd_ready = 1'b0;
    i2c_rd_data = 8'h00; i2c_rd_valid = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
    repeat (2) tick();
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_adc_valid", {31'd0, adc_data_valid}, 32'd0);
    chk("rst_cmd_ctrl", {24'd0, cmd_ctrl}, 32'd0);
    chk("rst_rd_len", {29'd0, cmd_rd_len}, 32'd0);
    chk("rst_errs", {30'd0, err_nack, err_timeout}, 32'd0);

    // Basic sweep over ch0/ch2, gap, then reset while a command is pending.
    do_reset();
    ch_mask = 4'b0101; scan_en = 1'b1;
    wait_cmd(8'h40, "t1_ch0");
    handshake();
    send_sample(8'h11, 8'h80);
    pulse_done();
    chk_pub("t1_ch0", 8'h80, 2'd0);
    tick();
    chk("t1_one_cycle", {31'd0, adc_data_valid}, 32'd0);
    wait_cmd(8'h42, "t1_ch2");
    handshake();
    send_sample(8'h22, 8'hC0);
    pulse_done();
    chk_pub("t1_ch2", 8'hC0, 2'd2);
    for (int n = 0; n < 50 && n_sweep == 0; n++) tick();
    chk("t1_sweep", 32'(n_sweep), 32'd1);
    wait_cmd(8'h40, "t1_next");
    chk("t1_gap", 32'(rise_cyc - sweep_cyc), 32'(Gap + 3));
    chk("t1_valid_cnt", 32'(n_valid), 32'd2);
    chk("t1_no_err", 32'(n_nack + n_to), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_drop", {31'd0, cmd_valid}, 32'd0);
    chk("t1_rst_busy", {31'd0, busy}, 32'd0);

    // Empty mask: nothing happens.
    do_reset();
    ch_mask = 4'b0000; scan_en = 1'b1;
    repeat (1000) tick();
    chk("t2_no_cmd", 32'(n_cmdv), 32'd0);
    chk("t2_no_busy", 32'(n_busy), 32'd0);

    // Back-pressure on ch1, then final byte coincident with STOP.
    do_reset();
    ch_mask = 4'b0010; scan_en = 1'b1;
    wait_cmd(8'h41, "t3_ch1");
    hold_bad = 0;
    repeat (20) begin
      tick();
      if (!cmd_valid || cmd_ctrl != 8'h41) hold_bad++;
    end
    chk("t3_hold", 32'(hold_bad), 32'd0);
    handshake();
    send_byte(8'h05, 1'b0);
    for (int i = 1; i < RdLen - 1; i++) send_byte(8'h66, 1'b0);
    send_byte(8'h66, 1'b1);
    chk_pub("t3_ch1", 8'h66, 2'd1);
    chk("t3_no_to", 32'(n_to), 32'd0);

    // Watchdog: no STOP on ch0, then ch1 proceeds.
    do_reset();
    ch_mask = 4'b0011; scan_en = 1'b1;
    wait_cmd(8'h40, "t4_ch0");
    handshake();
    send_sample(8'h01, 8'h02);
    for (int n = 0; n < 200 && n_to == 0; n++) tick();
    chk("t4_to_cnt", 32'(n_to), 32'd1);
    chk("t4_to_lat", 32'(to_cyc - hs_cyc), 32'(Tmo));
    chk("t4_no_valid", 32'(n_valid), 32'd0);
    wait_cmd(8'h41, "t4_ch1");
    handshake();
    send_sample(8'h00, 8'h33);
    pulse_done();
    chk_pub("t4_ch1", 8'h33, 2'd1);

    // NACK on ch1: error, no sample, sweep still completes.
    do_reset();
    ch_mask = 4'b0011; scan_en = 1'b1;
    wait_cmd(8'h40, "t5_ch0");
    handshake();
    send_sample(8'h00, 8'h37);
    pulse_done();
    chk_pub("t5_ch0", 8'h37, 2'd0);
    wait_cmd(8'h41, "t5_ch1");
    handshake();
    send_byte(8'h00, 1'b0);
    i2c_nack = 1'b1;
    tick();
    i2c_nack = 1'b0;
    chk("t5_err_nack", {31'd0, err_nack}, 32'd1);
    for (int n = 0; n < 50 && n_sweep == 0; n++) tick();
    chk("t5_sweep", 32'(n_sweep), 32'd1);
    chk("t5_valid_cnt", 32'(n_valid), 32'd1);
    chk("t5_nack_cnt", 32'(n_nack), 32'd1);

    // scan_en dropped mid ch0; extra bytes beyond the read length are ignored.
    do_reset();
    ch_mask = 4'b1111; scan_en = 1'b1;
    wait_cmd(8'h40, "t6_ch0");
    handshake();
    scan_en = 1'b0;
    send_byte(8'h99, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h30, 1'b0);
    send_byte(8'h41, 1'b0);
    pulse_done();
    chk_pub("t6_ch0", AvgExp, 2'd0);
    n_cmdv = 0; n_busy = 0;
    repeat (50) tick();
    chk("t6_no_cmd", 32'(n_cmdv), 32'd0);
    chk("t6_idle", 32'(n_busy), 32'd0);
    chk("t6_no_sweep", 32'(n_sweep), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
